// File: rtl/inst_fetch.sv
// Instruction fetch unit: single-outstanding imem requests feeding a 2-entry
// in-order queue (head + skid) that presents PC/instruction to decode.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_takeBranch,
    input  logic [31:0] i_jpc,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemAck,
    input  logic [31:0] i_imemData,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_valid
);

    typedef enum logic {
        FETCH,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic [31:0] stale_addr;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic        req;
    logic        req_next;
    logic [31:0] head_pc;
    logic [31:0] head_inst;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;
    logic        redirect;
    logic        pop;
    logic        push;

    assign o_valid    = (count != 2'd0);
    assign o_pc       = o_valid ? head_pc : 32'h0000_0000;
    assign o_inst     = o_valid ? head_inst : 32'h0000_0000;
    assign o_imemReq  = req;
    assign o_imemAddr = (state == DRAIN) ? stale_addr : fetch_pc;

    assign pop      = o_valid && !i_stall;
    assign redirect = i_takeBranch && pop;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= FETCH;
            fetch_pc   <= RESET_PC;
            stale_addr <= RESET_PC;
            count      <= 2'd0;
            req        <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            count    <= count_next;
            req      <= req_next;
            if (state == FETCH && state_next == DRAIN) begin
                stale_addr <= fetch_pc;
            end
        end
    end

    // A redirect that catches a request in flight must let it finish before
    // a new address can be issued, so the response is drained and dropped.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        count_next    = count;
        push          = 1'b0;

        case (state)
            FETCH: begin
                if (redirect) begin
                    fetch_pc_next = i_jpc;
                    if (req && !i_imemAck) begin
                        state_next = DRAIN;
                    end
                end else if (req && i_imemAck) begin
                    push          = 1'b1;
                    fetch_pc_next = fetch_pc + 32'd4;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_next = i_jpc;
                end
                if (req && i_imemAck) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase

        if (redirect) begin
            count_next = 2'd0;
        end else if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end

        req_next = (state_next == DRAIN) || (count_next < 2'd2);
    end

    // Head always holds the oldest entry; the skid slot only fills while the
    // head is stalled, which also throttles the request to keep count <= 2.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            head_pc   <= 32'h0000_0000;
            head_inst <= 32'h0000_0000;
            skid_pc   <= 32'h0000_0000;
            skid_inst <= 32'h0000_0000;
        end else if (!redirect) begin
            if (pop) begin
                if (count == 2'd2) begin
                    head_pc   <= skid_pc;
                    head_inst <= skid_inst;
                    if (push) begin
                        skid_pc   <= fetch_pc;
                        skid_inst <= i_imemData;
                    end
                end else if (push) begin
                    head_pc   <= fetch_pc;
                    head_inst <= i_imemData;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    head_pc   <= fetch_pc;
                    head_inst <= i_imemData;
                end else begin
                    skid_pc   <= fetch_pc;
                    skid_inst <= i_imemData;
                end
            end
        end
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 Port: i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: i_rst_n  input  1  synchronous, active-low reset.
REQ-004 Port: i_stall  input  1  downstream (IF/ID consumer) cannot accept the current instruction this cycle.
REQ-005 Port: i_takeBranch  input  1  decode-stage redirect request, qualified by o_valid && !i_stall.
REQ-006 Port: i_jpc  input  32  redirect target, sampled with i_takeBranch.
REQ-007 Port: o_imemReq  output  1  instruction-memory read request.
REQ-008 Port: o_imemAddr  output  32  read address; stable while o_imemReq=1 and no ack.
REQ-009 Port: i_imemAck  input  1  read complete; i_imemData valid in the same cycle; may arrive in the request's first cycle.
REQ-010 Port: i_imemData  input  32  fetched instruction word.
REQ-011 Port: o_pc  output  32  PC of the presented instruction.
REQ-012 Port: o_inst  output  32  presented instruction.
REQ-013 Port: o_valid  output  1  o_pc/o_inst hold a live instruction.

Function
REQ-014 Internal 2-entry in-order queue: head drives o_pc/o_inst/o_valid; second entry is a skid slot; count is 0..2.
REQ-015 When o_valid=0: o_pc=0 and o_inst=0 (decodes as nop).
REQ-016 Pop: the head is consumed in any cycle with o_valid && !i_stall; the skid entry, if present, becomes head next cycle.
REQ-017 Push: a cycle with o_imemReq && i_imemAck in FETCH state and no accepted redirect enqueues {fetchPc, i_imemData}; fetchPc advances by 4 (mod 2^32; 0xFFFFFFFC wraps to 0x00000000).
REQ-018 Pop and push in the same cycle keep count unchanged; order is preserved.
REQ-019 At most one outstanding request; o_imemAddr = fetchPc in FETCH and the stale address in DRAIN.
REQ-020 States: FETCH, DRAIN.
REQ-021 FETCH: o_imemReq=1 when registered count<2, else 0; once raised without ack it stays raised.
REQ-022 Throughput: with zero-wait memory and no stall, one instruction per cycle.
REQ-023 Accepted redirect (i_takeBranch && o_valid && !i_stall): queue cleared next cycle; fetchPc <= i_jpc (used unmodified).
REQ-024 Redirect with a request pending and no ack this cycle: go to DRAIN and hold req/address.
REQ-025 Redirect in a cycle that also has an ack: the ack data is discarded; stay in FETCH; the next request is to i_jpc.
REQ-026 DRAIN: o_imemReq=1 at the stale address; on ack, discard the data and go to FETCH. A further accepted redirect in DRAIN only updates fetchPc.
REQ-027 i_takeBranch is ignored when o_valid=0 or i_stall=1.
REQ-028 An ack while o_imemReq=0 is ignored.

Reset
REQ-029 When i_rst_n=0 at a rising edge: count=0, o_valid=0, o_pc=0, o_inst=0, state=FETCH, fetchPc=RESET_PC, o_imemReq=0 next cycle. A pending request is abandoned.
REQ-030 First cycle after reset release: o_imemReq=1 with o_imemAddr=RESET_PC.

Verification
REQ-031 Zero-wait memory (ack every req cycle), no stall -> o_valid=1 from the cycle after the first ack; o_pc sequence 0x0, 0x4, 0x8, ... one per cycle; instruction data matches memory.
REQ-032 With head o_pc=0x8, hold i_stall=1 for 3 cycles -> o_pc stays 0x8; skid takes 0x0C; o_imemReq=0 once count=2. After release -> 0x8, 0x0C, 0x10 in successive cycles; none lost or duplicated.
REQ-033 Head o_pc=0x10 valid; i_takeBranch=1, i_jpc=0x100, no stall -> next cycle o_valid=0, o_inst=0. Next valid o_pc=0x100; 0x14 never presented valid.
REQ-034 Ack latency 3; request to 0x14 pending; accepted redirect to 0x200 -> o_imemAddr holds 0x14 until ack; that data is discarded; next request is to 0x200; first valid o_pc=0x200.
REQ-035 Redirect to 0xFFFFFFFC -> presented 0xFFFFFFFC, then 0x00000000.
REQ-036 i_rst_n=0 for one cycle during a pending request -> next cycle o_valid=0, o_imemReq=0. After release: request to RESET_PC; a late ack for the old request while req=0 is ignored.
